// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : MIPS instruction-fetch stage. Holds the PC, addresses the
//             instruction memory and loads the IF/ID pipeline register.
//             It handles decode stalls and branch/jump redirects, and keeps
//             a saturating count of the instructions it has issued.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_next,
    output logic              if_valid,
    output logic [CNT_W-1:0]  issued_cnt
);

    localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] C_PC_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    logic [ADDR_W-1:0] pc_q,         pc_d;
    logic [DATA_W-1:0] if_instr_q,   if_instr_d;
    logic [ADDR_W-1:0] if_pc_q,      if_pc_d;
    logic [ADDR_W-1:0] if_pc_next_q, if_pc_next_d;
    logic              if_valid_q,   if_valid_d;
    logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;

    // Sequential PC increment; wraps naturally modulo 2^ADDR_W.
    logic [ADDR_W-1:0] w_pc_inc;
    assign w_pc_inc = pc_q + C_PC_ONE;

    // Next-state selection: redirect beats stall, stall beats normal fetch.
    always_comb begin
        pc_d         = pc_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_pc_next_d = if_pc_next_q;
        if_valid_d   = if_valid_q;
        issued_cnt_d = issued_cnt_q;
        if (redirect_en) begin
            // Squash the fetch in flight; if_pc/if_pc_next keep their old value.
            pc_d       = redirect_pc;
            if_instr_d = '0;
            if_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d         = w_pc_inc;
            if_instr_d   = imem_rd;
            if_pc_d      = pc_q;
            if_pc_next_d = w_pc_inc;
            if_valid_d   = 1'b1;
            if (!(&issued_cnt_q)) begin
                issued_cnt_d = issued_cnt_q + C_CNT_ONE;
            end
        end
    end

    // PC, IF/ID register and issue counter, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= C_RESET_PC;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            if_pc_next_q <= '0;
            if_valid_q   <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_pc_next_q <= if_pc_next_d;
            if_valid_q   <= if_valid_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign imem_addr  = pc_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_pc_next = if_pc_next_q;
    assign if_valid   = if_valid_q;
    assign issued_cnt = issued_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage. A small counter
//             width is used so saturation is reachable in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rd;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_pc_next;
    logic              if_valid;
    logic [CNT_W-1:0]  issued_cnt;

    logic [DATA_W-1:0] mem [0:255];

    int n_assert = 0;
    int n_fail   = 0;

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_next  (if_pc_next),
        .if_valid    (if_valid),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory model.
    assign imem_rd = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_instr,
                           input logic [7:0] e_pc, input logic [7:0] e_pcn,
                           input logic e_valid, input logic [3:0] e_cnt,
                           input logic [7:0] e_addr);
        chk({tag, ".if_instr"},   if_instr,          e_instr);
        chk({tag, ".if_pc"},      {24'd0, if_pc},      {24'd0, e_pc});
        chk({tag, ".if_pc_next"}, {24'd0, if_pc_next}, {24'd0, e_pcn});
        chk({tag, ".if_valid"},   {31'd0, if_valid},   {31'd0, e_valid});
        chk({tag, ".issued_cnt"}, {28'd0, issued_cnt}, {28'd0, e_cnt});
        chk({tag, ".imem_addr"},  {24'd0, imem_addr},  {24'd0, e_addr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | i;
        mem[0] = 32'h2001_0003;
        mem[1] = 32'h2002_0009;
        mem[2] = 32'h0022_1020;
        mem[3] = 32'h0022_1824;
        mem[4] = 32'h0022_2025;
        mem[255] = 32'hDEAD_00FF;

        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        #12;
        chk_all("reset", 32'h0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Free-running fetch of the first two words.
        step(); chk_all("run1", 32'h2001_0003, 8'h00, 8'h01, 1'b1, 4'd1, 8'h01);
        step(); chk_all("run2", 32'h2002_0009, 8'h01, 8'h02, 1'b1, 4'd2, 8'h02);

        // Stall for three edges: everything holds.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_all("stall", 32'h2002_0009, 8'h01, 8'h02, 1'b1, 4'd2, 8'h02);
        end
        stall = 1'b0;
        step(); chk_all("run3", 32'h0022_1020, 8'h02, 8'h03, 1'b1, 4'd3, 8'h03);
        step(); chk_all("run4", 32'h0022_1824, 8'h03, 8'h04, 1'b1, 4'd4, 8'h04);
        step(); chk_all("run5", 32'h0022_2025, 8'h04, 8'h05, 1'b1, 4'd5, 8'h05);

        // Redirect to 3, then redirect to 0 while pc=3.
        redirect_en = 1'b1; redirect_pc = 8'h03;
        step(); chk_all("redir3", 32'h0, 8'h04, 8'h05, 1'b0, 4'd5, 8'h03);
        redirect_pc = 8'h00;
        step(); chk_all("redir0", 32'h0, 8'h04, 8'h05, 1'b0, 4'd5, 8'h00);
        redirect_en = 1'b0;
        step(); chk_all("after_redir", 32'h2001_0003, 8'h00, 8'h01, 1'b1, 4'd6, 8'h01);

        // Redirect and stall together: redirect wins.
        redirect_en = 1'b1; stall = 1'b1; redirect_pc = 8'h04;
        step(); chk_all("redir_stall", 32'h0, 8'h00, 8'h01, 1'b0, 4'd6, 8'h04);
        stall = 1'b0;

        // PC wrap at 0xFF.
        redirect_pc = 8'hFF;
        step(); chk_all("redirFF", 32'h0, 8'h00, 8'h01, 1'b0, 4'd6, 8'hFF);
        redirect_en = 1'b0;
        step(); chk_all("wrapFF", 32'hDEAD_00FF, 8'hFF, 8'h00, 1'b1, 4'd7, 8'h00);
        step(); chk_all("wrap00", 32'h2001_0003, 8'h00, 8'h01, 1'b1, 4'd8, 8'h01);

        // Redirect to the current pc: one bubble, then re-fetch.
        redirect_en = 1'b1; redirect_pc = 8'h01;
        step(); chk_all("redir_same", 32'h0, 8'h00, 8'h01, 1'b0, 4'd8, 8'h01);
        redirect_en = 1'b0;
        step(); chk_all("refetch", 32'h2002_0009, 8'h01, 8'h02, 1'b1, 4'd9, 8'h02);

        // Async reset mid-cycle during a stall.
        stall = 1'b1;
        step(); chk_all("stall2", 32'h2002_0009, 8'h01, 8'h02, 1'b1, 4'd9, 8'h02);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;

        // Counter saturation at all-ones while pc keeps advancing.
        for (int k = 1; k <= 14; k++) step();
        step(); chk_all("cnt15", mem[14], 8'h0E, 8'h0F, 1'b1, 4'd15, 8'h0F);
        step(); chk_all("cnt_sat", mem[15], 8'h0F, 8'h10, 1'b1, 4'd15, 8'h10);
        step(); chk_all("cnt_sat2", mem[16], 8'h10, 8'h11, 1'b1, 4'd15, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
